grid_map_buffer: RTL and testbench

//  Downstream consumer of the click-driven coordinate generator (x/y/value/enable).
//  - Captures maze-cell writes, stores 2-bit cell state in an on-chip grid, serves VGA pixel lookups as 8-bit RGB332.
//  - The producer runs in a foreign clock domain (button edge), so all write inputs are synchronised here.

---
 rtl/grid_map_buffer_pkg.sv | 32 +++
 rtl/cdc_bus_sync.sv | 30 +++
 rtl/grid_map_buffer.sv | 172 +++++++++++++++++
 tb/tb_grid_map_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/grid_map_buffer_pkg.sv
// Shared encodings for the maze grid buffer: cell states, RGB332 colours and FSM states.
package grid_map_buffer_pkg;

    typedef enum logic [1:0] {
        CELL_UNEXPLORED = 2'd0,
        CELL_VISITED    = 2'd1,
        CELL_WALL       = 2'd2,
        CELL_ROBOT      = 2'd3
    } cell_e;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [7:0] COLOR_BLANK      = 8'h00;
    localparam logic [7:0] COLOR_UNEXPLORED = 8'h00;
    localparam logic [7:0] COLOR_VISITED    = 8'hE0;
    localparam logic [7:0] COLOR_WALL       = 8'h03;
    localparam logic [7:0] COLOR_ROBOT      = 8'h1C;
    localparam logic [7:0] COLOR_OUTSIDE    = 8'h92;

    function automatic logic [7:0] cell_color(input cell_e c);
        case (c)
            CELL_UNEXPLORED: return COLOR_UNEXPLORED;
            CELL_VISITED:    return COLOR_VISITED;
            CELL_WALL:       return COLOR_WALL;
            default:         return COLOR_ROBOT;
        endcase
    endfunction

endpackage

// File: rtl/cdc_bus_sync.sv
// Two-flop synchroniser for a slow-changing bus plus a third stage used to flag a settled sample.
module cdc_bus_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_async,
    output logic [WIDTH-1:0] q,
    output logic             stable
);

    logic [WIDTH-1:0] stage1_q, stage2_q, stage3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= '0;
            stage2_q <= '0;
            stage3_q <= '0;
        end else begin
            stage1_q <= d_async;
            stage2_q <= stage1_q;
            stage3_q <= stage2_q;
        end
    end

    // Bits may resolve on different cycles; only trust a value seen twice in a row.
    assign q      = stage2_q;
    assign stable = (stage2_q == stage3_q);

endmodule

// File: rtl/grid_map_buffer.sv
// Maze cell map: captures asynchronous cell writes, clears itself after reset and serves
// RGB332 pixel colours to the VGA scan-out with two cycles of latency.
module grid_map_buffer
    import grid_map_buffer_pkg::*;
#(
    parameter int unsigned GRID_W     = 11,
    parameter int unsigned GRID_H     = 11,
    parameter int unsigned CELL_SHIFT = 5,
    parameter logic [9:0]  X0         = 10'd0,
    parameter logic [9:0]  Y0         = 10'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [1:0] wr_value,
    input  logic       wr_en,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_valid,
    output logic [7:0] color,
    output logic       busy,
    output logic [7:0] wr_count,
    output logic       wr_drop
);

    localparam int unsigned NCELLS = GRID_W * GRID_H;
    localparam int unsigned IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q;
    cell_e            cells_q [NCELLS];

    logic [10:0] sync_bus;
    logic        sync_stable;
    logic        s_en;
    logic [9:0]  s_trip;
    logic        trigger;
    logic        last_en_q;
    logic [9:0]  last_trip_q;
    logic        pend_valid_q;
    logic [9:0]  pend_trip_q;

    logic             commit;
    logic [9:0]       c_trip;
    logic             in_range;
    logic [IDX_W-1:0] wr_idx;

    cdc_bus_sync #(
        .WIDTH (11)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .d_async ({wr_en, wr_x, wr_y, wr_value}),
        .q       (sync_bus),
        .stable  (sync_stable)
    );

    assign s_en   = sync_bus[10];
    assign s_trip = sync_bus[9:0];
    assign busy   = (state_q == ST_CLEAR);

    // last_trip_q records triggered triples even when dropped, so a held bad write pulses once.
    assign trigger = sync_stable && s_en && (!last_en_q || (s_trip != last_trip_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_idx_q == IDX_W'(NCELLS - 1)) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // A live trigger is newer than anything parked during the clear sweep.
    always_comb begin
        commit = 1'b0;
        c_trip = s_trip;
        if (state_q == ST_RUN) begin
            if (trigger) begin
                commit = 1'b1;
            end else if (pend_valid_q) begin
                commit = 1'b1;
                c_trip = pend_trip_q;
            end
        end
        in_range = (32'(c_trip[9:6]) < GRID_W) && (32'(c_trip[5:2]) < GRID_H);
        wr_idx   = IDX_W'(8'(c_trip[5:2]) * 8'(GRID_W) + 8'(c_trip[9:6]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            last_en_q    <= 1'b0;
            last_trip_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_trip_q  <= '0;
            wr_count     <= 8'd0;
            wr_drop      <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_drop <= 1'b0;
            if (sync_stable) last_en_q <= s_en;
            if (trigger) last_trip_q <= s_trip;
            if (state_q == ST_CLEAR) begin
                clr_idx_q <= clr_idx_q + IDX_W'(1);
                if (trigger) begin
                    pend_valid_q <= 1'b1;
                    pend_trip_q  <= s_trip;
                end
            end else begin
                pend_valid_q <= 1'b0;
                if (commit) begin
                    if (in_range) begin
                        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
                    end else begin
                        wr_drop <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                cells_q[clr_idx_q] <= CELL_UNEXPLORED;
            end else if (commit && in_range) begin
                cells_q[wr_idx] <= cell_e'(c_trip[1:0]);
            end
        end
    end

    // Read pipeline: stage 1 maps pixel to cell, stage 2 looks the cell up (old data on collision).
    logic [9:0]       rx, ry, cx, cy;
    logic             pix_inside;
    logic [IDX_W-1:0] pix_idx;
    logic             s1_valid_q, s1_inside_q;
    logic [IDX_W-1:0] s1_idx_q;

    always_comb begin
        rx         = pix_x - X0;
        ry         = pix_y - Y0;
        cx         = rx >> CELL_SHIFT;
        cy         = ry >> CELL_SHIFT;
        pix_inside = pix_valid && (pix_x >= X0) && (pix_y >= Y0)
                     && (32'(cx) < GRID_W) && (32'(cy) < GRID_H);
        pix_idx    = IDX_W'(8'(cy) * 8'(GRID_W) + 8'(cx));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_inside_q <= 1'b0;
            s1_idx_q    <= '0;
            color       <= COLOR_BLANK;
        end else begin
            s1_valid_q  <= pix_valid;
            s1_inside_q <= pix_inside;
            s1_idx_q    <= pix_idx;
            if (busy || !s1_valid_q) begin
                color <= COLOR_BLANK;
            end else if (!s1_inside_q) begin
                color <= COLOR_OUTSIDE;
            end else begin
                color <= cell_color(cells_q[s1_idx_q]);
            end
        end
    end

endmodule

// File: tb/tb_grid_map_buffer.sv
// Scoreboard bench for grid_map_buffer: pixel expectations queued at drive time, popped at output.
module tb_grid_map_buffer;

    localparam int GW = 11;
    localparam int GH = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] wr_x = '0;
    logic [3:0] wr_y = '0;
    logic [1:0] wr_value = '0;
    logic       wr_en = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       pix_valid = 1'b0;
    logic [7:0] color;
    logic       busy;
    logic [7:0] wr_count;
    logic       wr_drop;

    grid_map_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_value  (wr_value),
        .wr_en     (wr_en),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .color     (color),
        .busy      (busy),
        .wr_count  (wr_count),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [1:0] model [GW*GH];
    int         exp_count = 0;
    int         drop_seen = 0;
    logic [7:0] exp_q [$];
    logic       probe = 1'b0;
    logic [1:0] pipe = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_color(input int x, input int y, input bit v,
                                             input bit clearing);
        int cx, cy;
        if (clearing || !v) return 8'h00;
        cx = x / 32;
        cy = y / 32;
        if (cx >= GW || cy >= GH) return 8'h92;
        case (model[cy*GW+cx])
            2'd0:    return 8'h00;
            2'd1:    return 8'hE0;
            2'd2:    return 8'h03;
            default: return 8'h1C;
        endcase
    endfunction

    always @(posedge clk) pipe <= {pipe[0], probe};

    always @(negedge clk) begin
        if (wr_drop) drop_seen++;
        if (pipe[1]) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("color", color, exp_q.pop_front());
        end
    end

    task automatic probe_pix(input int x, input int y, input bit v, input bit clearing);
        @(posedge clk);
        #1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_valid = v;
        probe     = 1'b1;
        exp_q.push_back(exp_color(x, y, v, clearing));
        @(posedge clk);
        #1;
        probe     = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic drive_wr(input int x, input int y, input int v, input bit en);
        @(posedge clk);
        #3;
        wr_x     = 4'(x);
        wr_y     = 4'(y);
        wr_value = 2'(v);
        wr_en    = en;
        repeat (8) @(posedge clk);
    endtask

    task automatic commit_wr(input int x, input int y, input int v);
        drive_wr(x, y, v, 1'b1);
        if (x < GW && y < GH) begin
            model[y*GW+x] = 2'(v);
            if (exp_count < 255) exp_count++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_count", wr_count, 0);
        check("rst_color", color, 0);
        check("rst_drop", wr_drop, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        foreach (model[i]) model[i] = 2'd0;
        exp_count = 0;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        int drops_before;

        // Reset and clear sweep
        do_reset();
        wait_busy_low(n_busy);
        check("busy_cycles", n_busy, 121);
        probe_pix(0, 0, 1, 0);
        probe_pix(100, 70, 1, 0);
        probe_pix(351, 351, 1, 0);
        check("idle_count", wr_count, 0);

        // Single rising-enable write
        commit_wr(3, 2, 1);
        check("first_count", wr_count, exp_count);
        probe_pix(100, 70, 1, 0);
        repeat (10) @(posedge clk);
        check("no_repeat", wr_count, exp_count);

        // Enable held high, triple steps
        for (int x = 0; x < GW; x++) begin
            commit_wr(x, 5, 2);
            check("step_count", wr_count, exp_count);
        end
        commit_wr(0, 6, 2);
        check("step_row_count", wr_count, exp_count);
        probe_pix(4*32+5, 5*32+5, 1, 0);
        probe_pix(10*32+31, 5*32, 1, 0);
        probe_pix(0, 6*32+1, 1, 0);
        probe_pix(5, 7*32+8, 1, 0);

        // Out-of-range write
        drops_before = drop_seen;
        drive_wr(4, 11, 3, 1'b1);
        check("drop_pulses", drop_seen, drops_before + 1);
        check("drop_count", wr_count, exp_count);
        probe_pix(4*32, 10*32+2, 1, 0);
        probe_pix(500, 10, 1, 0);
        probe_pix(100, 70, 0, 0);
        probe_pix(351, 351, 1, 0);

        // Trigger parked during the clear sweep
        drive_wr(0, 0, 0, 1'b0);
        do_reset();
        repeat (50) @(posedge clk);
        #3;
        wr_x = 4'd0; wr_y = 4'd0; wr_value = 2'd2; wr_en = 1'b1;
        probe_pix(5, 5, 1, 1);
        wait_busy_low(n_busy);
        check("clear_done", busy, 0);
        repeat (6) @(posedge clk);
        model[0] = 2'd2;
        exp_count = 1;
        check("pend_count", wr_count, exp_count);
        probe_pix(5, 5, 1, 0);
        probe_pix(40, 5, 1, 0);

        // Reset in the middle of RUN
        for (int x = 1; x <= 5; x++) commit_wr(x, 0, 3);
        check("run_count", wr_count, exp_count);
        probe_pix(32, 0, 1, 0);
        drive_wr(5, 0, 3, 1'b0);
        do_reset();
        wait_busy_low(n_busy);
        check("busy_cycles_2", n_busy, 121);
        for (int cy = 0; cy < GH; cy++)
            for (int cx = 0; cx < GW; cx++)
                probe_pix(cx*32+16, cy*32+16, 1, 0);
        check("reclear_count", wr_count, 0);

        repeat (4) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
